// File: rtl/lap_timer_pkg.sv
// Shared race-timing definitions: FSM encoding and the centisecond divisor.
package lap_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } race_state_e;

    localparam int CENTISEC_PER_SEC = 100;

    // Clock cycles per centisecond; clamped so a tiny CLK_FREQ still ticks.
    function automatic int centisec_div(input int clk_freq);
        return (clk_freq / CENTISEC_PER_SEC < 1) ? 1 : clk_freq / CENTISEC_PER_SEC;
    endfunction

endpackage

// File: rtl/lap_timer_centisec_tick.sv
// Centisecond prescaler: counts 0..DIV-1 while enabled, one-cycle tick at terminal count.
module centisec_tick #(
    parameter int DIV = 650000
) (
    input  logic pclk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC  = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == TC);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lap_timer.sv
// Race lap timer: counts valid laps, tracks lap/race/last/best times in centiseconds.
//   state     | meaning
//   S_IDLE    | after reset, waiting for the first start
//   S_RUNNING | race in progress, timers counting, lap edges evaluated
//   S_DONE    | TOTAL_LAPS reached, all outputs frozen until start
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_FREQ   = 65000000,
    parameter int TOTAL_LAPS = 3,
    parameter int TIME_W     = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic              lap_finished,
    input  logic              checkpoints_passed,
    output logic [3:0]        lap_count,
    output logic [TIME_W-1:0] lap_time,
    output logic [TIME_W-1:0] last_lap,
    output logic [TIME_W-1:0] best_lap,
    output logic [TIME_W-1:0] race_time,
    output logic              lap_valid,
    output logic              race_done
);
    localparam int              DIV      = centisec_div(CLK_FREQ);
    localparam logic [TIME_W-1:0] T_MAX  = '1;
    localparam logic [TIME_W-1:0] T_ONE  = TIME_W'(1);
    localparam logic [3:0]      LAPS_END = 4'(TOTAL_LAPS);

    race_state_e       state_q, state_d;
    logic              lap_fin_q, lap_fin_d;
    logic              armed_q, armed_d;
    logic [3:0]        lap_count_q, lap_count_d;
    logic [TIME_W-1:0] lap_time_q, lap_time_d;
    logic [TIME_W-1:0] last_lap_q, last_lap_d;
    logic [TIME_W-1:0] best_lap_q, best_lap_d;
    logic [TIME_W-1:0] race_time_q, race_time_d;
    logic              lap_valid_q, lap_valid_d;

    logic running, tick, lap_edge, lap_ok;

    centisec_tick #(.DIV(DIV)) u_tick (
        .pclk (pclk),
        .rst  (rst),
        .en   (running),
        .clr  (start),
        .tick (tick)
    );

    // Start always wins over a coincident lap edge.
    assign lap_edge = lap_finished && !lap_fin_q && running && !start;
    assign lap_ok   = lap_edge && (armed_q || checkpoints_passed);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_RUNNING;
            S_RUNNING: if (!start && lap_ok && (lap_count_q + 4'd1 == LAPS_END)) state_d = S_DONE;
            S_DONE:    if (start) state_d = S_RUNNING;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running   = (state_q == S_RUNNING);
        race_done = (state_q == S_DONE);
    end

    always_comb begin
        lap_fin_d   = lap_finished;
        armed_d     = armed_q;
        lap_count_d = lap_count_q;
        lap_time_d  = lap_time_q;
        last_lap_d  = last_lap_q;
        best_lap_d  = best_lap_q;
        race_time_d = race_time_q;
        lap_valid_d = 1'b0;
        if (start) begin
            armed_d     = 1'b0;
            lap_count_d = '0;
            lap_time_d  = '0;
            last_lap_d  = '0;
            best_lap_d  = T_MAX;
            race_time_d = '0;
        end else if (running) begin
            if (lap_edge) begin
                armed_d = 1'b0;
            end else if (checkpoints_passed) begin
                armed_d = 1'b1;
            end
            if (tick && race_time_q != T_MAX) begin
                race_time_d = race_time_q + T_ONE;
            end
            if (lap_ok) begin
                lap_valid_d = 1'b1;
                lap_count_d = lap_count_q + 4'd1;
                last_lap_d  = lap_time_q;
                best_lap_d  = (lap_time_q < best_lap_q) ? lap_time_q : best_lap_q;
                lap_time_d  = '0;
            end else if (tick && lap_time_q != T_MAX) begin
                lap_time_d = lap_time_q + T_ONE;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lap_fin_q   <= 1'b0;
            armed_q     <= 1'b0;
            lap_count_q <= '0;
            lap_time_q  <= '0;
            last_lap_q  <= '0;
            best_lap_q  <= T_MAX;
            race_time_q <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_fin_q   <= lap_fin_d;
            armed_q     <= armed_d;
            lap_count_q <= lap_count_d;
            lap_time_q  <= lap_time_d;
            last_lap_q  <= last_lap_d;
            best_lap_q  <= best_lap_d;
            race_time_q <= race_time_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_count = lap_count_q;
    assign lap_time  = lap_time_q;
    assign last_lap  = last_lap_q;
    assign best_lap  = best_lap_q;
    assign race_time = race_time_q;
    assign lap_valid = lap_valid_q;

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with CLK_FREQ=1000 (tick every 10 cycles) and TOTAL_LAPS=2.
module tb_lap_timer;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        start = 1'b0;
    logic        lap_finished = 1'b0;
    logic        checkpoints_passed = 1'b0;
    logic [3:0]  lap_count;
    logic [15:0] lap_time, last_lap, best_lap, race_time;
    logic        lap_valid, race_done;

    int n_cmp  = 0;
    int n_fail = 0;

    lap_timer #(.CLK_FREQ(1000), .TOTAL_LAPS(2), .TIME_W(16)) dut (
        .pclk               (pclk),
        .rst                (rst),
        .start              (start),
        .lap_finished       (lap_finished),
        .checkpoints_passed (checkpoints_passed),
        .lap_count          (lap_count),
        .lap_time           (lap_time),
        .last_lap           (last_lap),
        .best_lap           (best_lap),
        .race_time          (race_time),
        .lap_valid          (lap_valid),
        .race_done          (race_done)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        string       name;
        logic        st, lf, cp;
        int          n;
        logic [3:0]  cnt;
        logic [15:0] lt, rt, ll, bl;
        logic        lv, rd;
    } vec_t;

    vec_t vq[$];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input vec_t v);
        chk({v.name, ".lap_count"}, {12'h0, lap_count}, {12'h0, v.cnt});
        chk({v.name, ".lap_time"},  lap_time,  v.lt);
        chk({v.name, ".race_time"}, race_time, v.rt);
        chk({v.name, ".last_lap"},  last_lap,  v.ll);
        chk({v.name, ".best_lap"},  best_lap,  v.bl);
        chk({v.name, ".lap_valid"}, {15'h0, lap_valid}, {15'h0, v.lv});
        chk({v.name, ".race_done"}, {15'h0, race_done}, {15'h0, v.rd});
    endtask

    initial begin
        //              name         st    lf    cp    n    cnt   lt     rt     ll     bl        lv    rd
        vq.push_back('{"start0",    1'b1, 1'b0, 1'b0,   1, 4'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"run95",     1'b0, 1'b0, 1'b0,  95, 4'd0, 16'd9, 16'd9, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"unarmed",   1'b0, 1'b1, 1'b0,   1, 4'd0, 16'd9, 16'd9, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"keepcount", 1'b0, 1'b0, 1'b0,   4, 4'd0, 16'd10, 16'd10, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"arm1",      1'b0, 1'b0, 1'b1,   1, 4'd0, 16'd10, 16'd10, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"to40",      1'b0, 1'b0, 1'b0, 299, 4'd0, 16'd40, 16'd40, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"lap1",      1'b0, 1'b1, 1'b0,   1, 4'd1, 16'd0, 16'd40, 16'd40, 16'd40, 1'b1, 1'b0});
        vq.push_back('{"lap1_post", 1'b0, 1'b0, 1'b0,   1, 4'd1, 16'd0, 16'd40, 16'd40, 16'd40, 1'b0, 1'b0});
        vq.push_back('{"arm2",      1'b0, 1'b0, 1'b1,   1, 4'd1, 16'd0, 16'd40, 16'd40, 16'd40, 1'b0, 1'b0});
        vq.push_back('{"to30",      1'b0, 1'b0, 1'b0, 297, 4'd1, 16'd30, 16'd70, 16'd40, 16'd40, 1'b0, 1'b0});
        vq.push_back('{"lap2",      1'b0, 1'b1, 1'b0,   1, 4'd2, 16'd0, 16'd70, 16'd30, 16'd30, 1'b1, 1'b1});
        vq.push_back('{"done_post", 1'b0, 1'b0, 1'b0,   1, 4'd2, 16'd0, 16'd70, 16'd30, 16'd30, 1'b0, 1'b1});
        vq.push_back('{"frz_ticks", 1'b0, 1'b0, 1'b0,  30, 4'd2, 16'd0, 16'd70, 16'd30, 16'd30, 1'b0, 1'b1});
        vq.push_back('{"frz_edge",  1'b0, 1'b1, 1'b1,   1, 4'd2, 16'd0, 16'd70, 16'd30, 16'd30, 1'b0, 1'b1});
        vq.push_back('{"frz_more",  1'b0, 1'b0, 1'b0,  20, 4'd2, 16'd0, 16'd70, 16'd30, 16'd30, 1'b0, 1'b1});
        vq.push_back('{"restart",   1'b1, 1'b0, 1'b0,   1, 4'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"run25",     1'b0, 1'b0, 1'b0,  25, 4'd0, 16'd2, 16'd2, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"arm3",      1'b0, 1'b0, 1'b1,   1, 4'd0, 16'd2, 16'd2, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"to29",      1'b0, 1'b0, 1'b0,   3, 4'd0, 16'd2, 16'd2, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"lap_tick",  1'b0, 1'b1, 1'b0,   1, 4'd1, 16'd0, 16'd3, 16'd2, 16'd2, 1'b1, 1'b0});
        vq.push_back('{"lt_post",   1'b0, 1'b0, 1'b0,   1, 4'd1, 16'd0, 16'd3, 16'd2, 16'd2, 1'b0, 1'b0});
        vq.push_back('{"arm4",      1'b0, 1'b0, 1'b1,   1, 4'd1, 16'd0, 16'd3, 16'd2, 16'd2, 1'b0, 1'b0});
        vq.push_back('{"start_edge",1'b1, 1'b1, 1'b1,   1, 4'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"se_post",   1'b0, 1'b0, 1'b0,   1, 4'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0, 1'b0});
        vq.push_back('{"run31",     1'b0, 1'b0, 1'b0,  30, 4'd0, 16'd3, 16'd3, 16'd0, 16'hFFFF, 1'b0, 1'b0});

        // Reset values while rst is held.
        step(3);
        chk("rst.lap_count", {12'h0, lap_count}, 16'h0);
        chk("rst.race_time", race_time, 16'h0);
        chk("rst.best_lap",  best_lap,  16'hFFFF);
        chk("rst.lap_valid", {15'h0, lap_valid}, 16'h0);
        chk("rst.race_done", {15'h0, race_done}, 16'h0);
        rst = 1'b0;
        step(2);

        // Lap edges in IDLE are ignored and nothing counts.
        checkpoints_passed = 1'b1;
        lap_finished = 1'b1;
        step(1);
        chk("idle.lap_valid", {15'h0, lap_valid}, 16'h0);
        lap_finished = 1'b0;
        checkpoints_passed = 1'b0;
        step(20);
        chk("idle.lap_count", {12'h0, lap_count}, 16'h0);
        chk("idle.race_time", race_time, 16'h0);
        chk("idle.lap_time",  lap_time,  16'h0);

        foreach (vq[i]) begin
            start = vq[i].st;
            lap_finished = vq[i].lf;
            checkpoints_passed = vq[i].cp;
            step(vq[i].n);
            chk_all(vq[i]);
        end
        start = 1'b0;
        lap_finished = 1'b0;
        checkpoints_passed = 1'b0;

        // Asynchronous reset mid-race, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.race_time", race_time, 16'h0);
        chk("arst.lap_time",  lap_time,  16'h0);
        chk("arst.best_lap",  best_lap,  16'hFFFF);
        step(2);
        rst = 1'b0;
        step(30);
        chk("arst_idle.race_time", race_time, 16'h0);
        chk("arst_idle.lap_time",  lap_time,  16'h0);
        chk("arst_idle.race_done", {15'h0, race_done}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter CLK_FREQ, default 65000000, pclk frequency in Hz.
REQ-002 Parameter TOTAL_LAPS, default 3, number of valid laps that ends the race (range 1..15).
REQ-003 Parameter TIME_W, default 16, width of all time values, in centiseconds.
REQ-004 pclk  input  1  system clock, all state on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse from the game FSM that (re)starts the race.
REQ-007 lap_finished  input  1  level from the checkpoint stage; high while the car is on the finish line.
REQ-008 checkpoints_passed  input  1  level from the checkpoint stage; high when all six checkpoints are collected.
REQ-009 lap_count  output  4  number of valid laps completed.
REQ-010 lap_time  output  TIME_W  elapsed time of the current lap.
REQ-011 last_lap  output  TIME_W  time of the most recent valid lap.
REQ-012 best_lap  output  TIME_W  minimum valid lap time; all-ones when there is none.
REQ-013 race_time  output  TIME_W  total elapsed race time.
REQ-014 lap_valid  output  1  one-cycle pulse on each counted lap.
REQ-015 race_done  output  1  high while in state DONE.

Function
REQ-016 FSM states: IDLE, RUNNING, DONE.
- IDLE -> RUNNING on start.
- RUNNING -> DONE on the valid lap that makes lap_count equal TOTAL_LAPS.
- DONE -> RUNNING on start.
REQ-017 A start pulse in any state clears lap_count, lap_time, race_time, last_lap, prescaler and armed, and sets best_lap to all-ones, all in the next cycle. A start in RUNNING restarts the race.
REQ-018 Prescaler:
- Counts 0..CLK_FREQ/100-1 in RUNNING only and produces a one-cycle tick at the terminal count.
- Holds its value in IDLE and DONE.
REQ-019 On a tick in RUNNING, lap_time and race_time each increment by 1 and saturate at all-ones, with no wrap.
REQ-020 lap_finished is registered once. A lap edge is lap_finished high while its registered copy is low.
REQ-021 The armed flag:
- Sets in any RUNNING cycle where checkpoints_passed=1.
- Clears on every lap edge.
REQ-022 A lap edge is valid when (armed=1 or checkpoints_passed=1) in the edge cycle. Otherwise it is ignored: no counters change except that armed clears.
REQ-023 On a valid lap edge, in the next cycle:
- last_lap = lap_time.
- best_lap = min(best_lap, lap_time).
- lap_count increments.
- lap_time = 0. A tick coinciding with the edge is dropped for lap_time but still counted in race_time.
- lap_valid = 1 for exactly one cycle.
REQ-024 In DONE, all time and count outputs freeze and race_done=1.
REQ-025 Lap edges are ignored in IDLE and DONE.
REQ-026 A start in the same cycle as a lap edge gives start priority; the edge is discarded.
REQ-027 Outputs are registered; there is one cycle of latency from edge or tick to output.

Reset
REQ-028 rst asynchronously forces:
- FSM to IDLE.
- lap_count, lap_time, last_lap, race_time, prescaler to 0.
- best_lap to all-ones.
- armed, lap_valid, race_done and the lap_finished register to 0.
REQ-029 A reset mid-race abandons the race. A start is required to run again.

Structure
REQ-030 The FSM state encoding and the centisecond divisor constant CLK_FREQ/100 belong in the shared game package.
REQ-031 The prescaler is a sub-module named centisec_tick, with inputs pclk, rst, en, clr and output tick.

Verification (CLK_FREQ=1000, tick every 10 cycles, TOTAL_LAPS=2)
REQ-032 Reset then start; hold 95 cycles -> race_time=9, lap_time=9, lap_count=0, race_done=0.
REQ-033 Lap edge with checkpoints_passed never asserted -> lap_valid stays 0, lap_count=0, lap_time keeps counting.
REQ-034 Pulse checkpoints_passed for 1 cycle, drop it, then a lap edge at lap_time=40 -> lap_valid pulse, last_lap=40, best_lap=40, lap_count=1, lap_time=0.
REQ-035 Second valid lap at lap_time=30 -> last_lap=30, best_lap=30, lap_count=2, race_done=1. Further ticks and edges leave all outputs frozen.
REQ-036 Start in DONE -> counts cleared, best_lap=0xFFFF, state RUNNING. rst asserted mid-race -> IDLE immediately, without waiting for a clock edge.
REQ-037 Start and a valid lap edge in the same cycle -> lap_count=0 and no lap_valid pulse.
